// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory responder and its lane aligner.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00ff;
      SZ_H:    m = 64'h0000_0000_0000_ffff;
      SZ_W:    m = 64'h0000_0000_ffff_ffff;
      default: m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Byte-lane steering: right-aligns load data and merges store bytes into a 64-bit word.
module data_mem_lane_align
  import mem_pkg::*;
(
  input  logic [63:0] rd_word,
  input  logic [2:0]  byte_off,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  output logic [63:0] ld_data,
  output logic [63:0] st_word
);

  logic [5:0]  shamt;
  logic [63:0] lane_mask;

  always_comb begin
    shamt     = {byte_off, 3'b000};
    lane_mask = size_mask(size) << shamt;
    ld_data   = (rd_word >> shamt) & size_mask(size);
    st_word   = (rd_word & ~lane_mask) | ((wdata & size_mask(size)) << shamt);
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, programmable wait, valid/ready response.
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down the programmed latency
// RESP  | response held until the processor takes it
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [63:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        acc_we;
  logic [1:0]  acc_size;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic        misalign, out_of_range, acc_err;
  logic        access, mem_we;
  logic [63:0] rd_word, ld_data, st_word;

  // With zero latency the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    case (acc_size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = acc_addr[0];
      SZ_W:    misalign = |acc_addr[1:0];
      default: misalign = |acc_addr[2:0];
    endcase
    out_of_range = (acc_addr[63:3] >= 61'(DEPTH_WORDS));
    acc_err      = misalign | out_of_range;
    rd_word      = mem[acc_addr[AW+2:3]];
  end

  data_mem_lane_align u_align (
    .rd_word  (rd_word),
    .byte_off (acc_addr[2:0]),
    .size     (acc_size),
    .wdata    (acc_wdata),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          size_d      = req_size;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = 4'(LATENCY);
          req_ready_d = 1'b0;
          if (LATENCY == 0) access = 1'b1;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) access = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          rsp_rdata_d = 64'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
    if (access) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_we || acc_err) ? 64'd0 : ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is never cleared; gating with reset keeps a store from landing while held in reset.
  assign mem_we = access & acc_we & ~acc_err & reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr[AW+2:3]] <= st_word;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance plus a LATENCY=0 instance.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid0;
  logic        req_ready, req_ready0;
  logic        req_we;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_valid0;
  logic        rsp_ready;
  logic [63:0] rsp_rdata, rsp_rdata0;
  logic        rsp_err, rsp_err0;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [128];
  logic [63:0] rd;
  logic        er;
  int          lat;
  int          n;
  int          diffs;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; latency counts cycles from the accept edge to rsp_valid.
  task automatic access(input bit sel, input bit we, input logic [1:0] sz,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] rdo, output logic ero, output int lato);
    int k;
    logic tmo;
    tmo = 1'b0;
    @(negedge clk);
    req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    k = 0;
    while (!(sel ? req_ready0 : req_ready) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) tmo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid0 = 1'b0;
    lato = 1;
    while (!(sel ? rsp_valid0 : rsp_valid) && lato < 50) begin @(negedge clk); lato++; end
    if (lato >= 50) tmo = 1'b1;
    rdo = sel ? rsp_rdata0 : rsp_rdata;
    ero = sel ? rsp_err0 : rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("no_timeout", 64'(tmo), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_size = SZ_B; req_addr = 64'd0; req_wdata = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err",   64'(rsp_err), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 128; i++) begin
      model[i] = {32'(i), 32'ha5a5_0000 ^ 32'(i)};
      u_dut.mem[i] = model[i];
    end
    model[32] = 64'h1234_5678_90ab_cdef;
    u_dut.mem[32]  = model[32];
    u_dut0.mem[32] = model[32];

    access(1'b0, 1'b0, SZ_D, 64'h100, 64'd0, rd, er, lat);
    check("ld_d_data", rd, 64'h1234_5678_90ab_cdef);
    check("ld_d_err",  64'(er), 64'd0);
    check("ld_d_lat2", 64'(lat), 64'd3);

    access(1'b1, 1'b0, SZ_D, 64'h100, 64'd0, rd, er, lat);
    check("lat0_data", rd, 64'h1234_5678_90ab_cdef);
    check("lat0_lat",  64'(lat), 64'd1);

    access(1'b0, 1'b1, SZ_D, 64'h200, 64'h0000_0000_0000_000b, rd, er, lat);
    model[64] = 64'h0000_0000_0000_000b;
    check("st_d_rdata", rd, 64'd0);
    check("st_d_err",   64'(er), 64'd0);
    check("st_d_mem",   u_dut.mem[64], 64'h0000_0000_0000_000b);
    access(1'b0, 1'b0, SZ_D, 64'h200, 64'd0, rd, er, lat);
    check("reload_d", rd, 64'h0000_0000_0000_000b);

    access(1'b0, 1'b1, SZ_B, 64'h203, 64'h0000_0000_0000_00aa, rd, er, lat);
    model[64] = 64'h0000_0000_aa00_000b;
    check("st_b_mem", u_dut.mem[64], 64'h0000_0000_aa00_000b);
    access(1'b0, 1'b0, SZ_B, 64'h203, 64'd0, rd, er, lat);
    check("ld_b_203", rd, 64'h0000_0000_0000_00aa);
    access(1'b0, 1'b0, SZ_H, 64'h202, 64'd0, rd, er, lat);
    check("ld_h_202", rd, 64'h0000_0000_0000_aa00);

    access(1'b0, 1'b0, SZ_D, 64'h104, 64'd0, rd, er, lat);
    check("misal_ld_err",   64'(er), 64'd1);
    check("misal_ld_rdata", rd, 64'd0);
    check("misal_ld_lat",   64'(lat), 64'd3);
    access(1'b0, 1'b1, SZ_H, 64'h201, 64'hffff_ffff_ffff_ffff, rd, er, lat);
    check("misal_st_err", 64'(er), 64'd1);
    access(1'b0, 1'b1, SZ_D, 64'h400, 64'hffff_ffff_ffff_ffff, rd, er, lat);
    check("oor_st_err",   64'(er), 64'd1);
    check("oor_st_rdata", rd, 64'd0);
    diffs = 0;
    for (int i = 0; i < 128; i++) if (u_dut.mem[i] !== model[i]) diffs++;
    check("err_st_mem_unchanged", 64'(diffs), 64'd0);

    // Backpressure: response held while a second request waits.
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_D; req_addr = 64'h100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_addr = 64'h200;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_wait_ok", 64'(n < 50), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_rdata", rsp_rdata, 64'h1234_5678_90ab_cdef);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_after_hs_valid", 64'(rsp_valid), 64'd0);
    check("bp_after_hs_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", 64'(req_ready), 64'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_second_data", rsp_rdata, 64'h0000_0000_aa00_000b);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during WAIT must drop the pending store.
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_D; req_addr = 64'h200; req_wdata = 64'hff; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mid_req_ready", 64'(req_ready), 64'd1);
    check("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_mid_mem", u_dut.mem[64], 64'h0000_0000_aa00_000b);
    access(1'b0, 1'b0, SZ_D, 64'h200, 64'd0, rd, er, lat);
    check("post_rst_ld", rd, 64'h0000_0000_aa00_000b);
    check("post_rst_lat", 64'(lat), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
